// File: rtl/inference_pkg.sv
// Shared constants and types for the MNIST inference path.
// Optional feature macro used by the scheduler: SCHED_SEQ_EN.
package inference_pkg;
    localparam int NUM_PIXELS  = 784;
    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_RUNNING = 2'd2
    } bank_state_e;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
endpackage

// File: rtl/inference_scheduler_if.sv
// Pixel, engine and result signals of the inference scheduler.
// SCHED_SEQ_EN adds the per-result image sequence number res_seq.
interface inference_scheduler_if;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       img_abort;
    logic       pix_drop;
    logic       weights_ready;
    logic       eng_start;
    logic       eng_busy;
    logic       eng_done;
    logic [3:0] eng_digit;
    logic [9:0] eng_input_addr;
    logic [7:0] eng_input_pixel;
    logic       res_valid;
    logic [3:0] res_digit;
    logic       res_ready;
    logic [1:0] bank_full;
`ifdef SCHED_SEQ_EN
    logic [7:0] res_seq;
`endif

    modport slave (
`ifdef SCHED_SEQ_EN
        output res_seq,
`endif
        input  pix_valid, pix_data, img_abort, weights_ready,
        input  eng_busy, eng_done, eng_digit, eng_input_addr, res_ready,
        output pix_ready, pix_drop, eng_start, eng_input_pixel,
        output res_valid, res_digit, bank_full
    );

    modport master (
`ifdef SCHED_SEQ_EN
        input  res_seq,
`endif
        output pix_valid, pix_data, img_abort, weights_ready,
        output eng_busy, eng_done, eng_digit, eng_input_addr, res_ready,
        input  pix_ready, pix_drop, eng_start, eng_input_pixel,
        input  res_valid, res_digit, bank_full
    );
endinterface

// File: rtl/image_bank_ram.sv
// Two-bank image store: one write port, one registered read port.
// Address MSB selects the bank; reads past the image return 0.
module image_bank_ram
    import inference_pkg::*;
#(
    parameter int DEPTH = NUM_PIXELS,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW:0]   raddr_i,
    output logic [7:0]    rdata_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0] mem_q [2][DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i[AW]][waddr_i[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst)                         rdata_q <= '0;
        else if (raddr_i[AW-1:0] <= LAST) rdata_q <= mem_q[raddr_i[AW]][raddr_i[AW-1:0]];
        else                             rdata_q <= '0;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/inference_scheduler.sv
// Ping-pong image buffer, engine launch FSM and result FIFO for MNIST inference.
// Define SCHED_SEQ_EN to tag each result with an 8-bit image sequence number.
module inference_scheduler
    import inference_pkg::*;
#(
    parameter int NUM_PIXELS   = inference_pkg::NUM_PIXELS,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inference_scheduler_if.slave  bus
);
    localparam int             CW       = $clog2(RESULT_DEPTH);
    localparam logic [9:0]     LAST_PIX = 10'(NUM_PIXELS - 1);
    localparam logic [CW:0]    DEPTH_C  = (CW+1)'(RESULT_DEPTH);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [9:0]  wr_cnt_q, wr_cnt_d;
    logic [1:0]  fsm_q, fsm_d;
    logic        eng_start_q, eng_start_d;
    logic        pix_drop_q, pix_drop_d;

    logic [3:0]  fifo_dig_q [RESULT_DEPTH];
    logic [CW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW:0] cnt_q;

    logic accept, launch, retire, pop;

`ifdef SCHED_SEQ_EN
    logic [7:0] seq_q, seq_d;
    logic [7:0] bank_seq_q [2];
    logic [7:0] bank_seq_d [2];
    logic [7:0] fifo_seq_q [RESULT_DEPTH];
`endif

    assign bus.pix_ready = (bank_q[wr_bank_q] == BANK_EMPTY);
    assign accept = bus.pix_valid && bus.pix_ready && !bus.img_abort;
    assign launch = (fsm_q == S_IDLE) && (bank_q[rd_bank_q] == BANK_FULL) &&
                    bus.weights_ready && !bus.eng_busy && (cnt_q < DEPTH_C);
    assign retire = (fsm_q == S_RUN) && bus.eng_done;
    assign pop    = bus.res_valid && bus.res_ready;

    always_comb begin
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        fsm_d       = fsm_q;
        eng_start_d = 1'b0;
        pix_drop_d  = pix_drop_q | (bus.pix_valid && !bus.pix_ready);
`ifdef SCHED_SEQ_EN
        seq_d       = seq_q;
        bank_seq_d  = bank_seq_q;
`endif
        // Abort only rewinds the fill pointer; an aborted image never reaches FULL.
        if (bus.img_abort) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            if (wr_cnt_q == LAST_PIX) begin
                wr_cnt_d          = '0;
                bank_d[wr_bank_q] = BANK_FULL;
                wr_bank_d         = ~wr_bank_q;
`ifdef SCHED_SEQ_EN
                bank_seq_d[wr_bank_q] = seq_q;
                seq_d                 = seq_q + 8'd1;
`endif
            end else begin
                wr_cnt_d = wr_cnt_q + 10'd1;
            end
        end

        case (fsm_q)
            S_IDLE: if (launch) begin
                fsm_d             = S_START;
                eng_start_d       = 1'b1;
                bank_d[rd_bank_q] = BANK_RUNNING;
            end
            S_START: if (bus.eng_busy) fsm_d = S_RUN;
            S_RUN: if (bus.eng_done) begin
                fsm_d             = S_IDLE;
                bank_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d         = ~rd_bank_q;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q      <= '{BANK_EMPTY, BANK_EMPTY};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            fsm_q       <= S_IDLE;
            eng_start_q <= 1'b0;
            pix_drop_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
`ifdef SCHED_SEQ_EN
            seq_q       <= '0;
            bank_seq_q  <= '{8'd0, 8'd0};
`endif
        end else begin
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            fsm_q       <= fsm_d;
            eng_start_q <= eng_start_d;
            pix_drop_q  <= pix_drop_d;
`ifdef SCHED_SEQ_EN
            seq_q       <= seq_d;
            bank_seq_q  <= bank_seq_d;
`endif
            if (retire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({retire, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Launch gating keeps the FIFO from ever being pushed while full.
    always_ff @(posedge clk) begin
        if (retire) begin
            fifo_dig_q[wr_ptr_q] <= bus.eng_digit;
`ifdef SCHED_SEQ_EN
            fifo_seq_q[wr_ptr_q] <= bank_seq_q[rd_bank_q];
`endif
        end
    end

    assign bus.res_valid = (cnt_q != '0);
    assign bus.res_digit = bus.res_valid ? fifo_dig_q[rd_ptr_q] : 4'd0;
`ifdef SCHED_SEQ_EN
    assign bus.res_seq   = bus.res_valid ? fifo_seq_q[rd_ptr_q] : 8'd0;
`endif
    assign bus.eng_start = eng_start_q;
    assign bus.pix_drop  = pix_drop_q;
    assign bus.bank_full = {bank_q[1] != BANK_EMPTY, bank_q[0] != BANK_EMPTY};

    image_bank_ram #(.DEPTH(NUM_PIXELS), .AW(10)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, wr_cnt_q}),
        .wdata_i (bus.pix_data),
        .raddr_i ({rd_bank_q, bus.eng_input_addr}),
        .rdata_o (bus.eng_input_pixel)
    );
endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: read-back tables plus hand-written
// multi-image sequences against a simple engine responder.
module tb_inference_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inference_scheduler_if ifc();
    inference_scheduler dut (.clk(clk), .rst(rst), .bus(ifc));

    int errors = 0;
    int checks = 0;
    int launches = 0;
    logic       done_req = 1'b0;
    logic [3:0] done_dig = 4'd0;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t tab1 [5];
    rd_vec_t tab2 [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input int n, input int off);
        for (int i = 0; i < n; i++) begin
            ifc.pix_valid = 1'b1;
            ifc.pix_data  = 8'((i + off) % 128);
            step();
        end
        ifc.pix_valid = 1'b0;
    endtask

    task automatic engine_done(input logic [3:0] d);
        int t = 0;
        while (!ifc.eng_busy && t < 50) begin
            step();
            t++;
        end
        chk("engine running", 32'(ifc.eng_busy), 32'd1);
        done_req = 1'b1;
        done_dig = d;
        step();
        step();
    endtask

    task automatic pop_chk(input logic [3:0] d);
        chk("res_valid before pop", 32'(ifc.res_valid), 32'd1);
        chk("res_digit", 32'(ifc.res_digit), 32'(d));
        ifc.res_ready = 1'b1;
        step();
        ifc.res_ready = 1'b0;
    endtask

    task automatic run_table(input rd_vec_t tab [], input string name);
        for (int i = 0; i < tab.size(); i++) begin
            ifc.eng_input_addr = tab[i].addr;
            step();
            chk(name, 32'(ifc.eng_input_pixel), 32'(tab[i].exp));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pix_ready"},       32'(ifc.pix_ready), 32'd1);
        chk({tag, " pix_drop"},        32'(ifc.pix_drop), 32'd0);
        chk({tag, " eng_start"},       32'(ifc.eng_start), 32'd0);
        chk({tag, " res_valid"},       32'(ifc.res_valid), 32'd0);
        chk({tag, " res_digit"},       32'(ifc.res_digit), 32'd0);
        chk({tag, " bank_full"},       32'(ifc.bank_full), 32'd0);
        chk({tag, " eng_input_pixel"}, 32'(ifc.eng_input_pixel), 32'd0);
    endtask

    // Engine model: goes busy after a start, pulses done on request, reset by rst.
    initial begin
        ifc.eng_busy  = 1'b0;
        ifc.eng_done  = 1'b0;
        ifc.eng_digit = 4'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                ifc.eng_busy = 1'b0;
                ifc.eng_done = 1'b0;
                done_req     = 1'b0;
            end else if (done_req) begin
                ifc.eng_done  = 1'b1;
                ifc.eng_digit = done_dig;
                ifc.eng_busy  = 1'b0;
                done_req      = 1'b0;
            end else begin
                ifc.eng_done = 1'b0;
                if (ifc.eng_start) ifc.eng_busy = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (ifc.eng_start) launches++;
        end
    end

    initial begin
        int l0;
        tab1[0] = '{10'd0,   8'd0};
        tab1[1] = '{10'd5,   8'd5};
        tab1[2] = '{10'd127, 8'd127};
        tab1[3] = '{10'd128, 8'd0};
        tab1[4] = '{10'd783, 8'd15};
        tab2[0] = '{10'd0,   8'd0};
        tab2[1] = '{10'd5,   8'd5};
        tab2[2] = '{10'd300, 8'd44};
        tab2[3] = '{10'd783, 8'd15};

        ifc.pix_valid      = 1'b0;
        ifc.pix_data       = 8'd0;
        ifc.img_abort      = 1'b0;
        ifc.weights_ready  = 1'b1;
        ifc.eng_input_addr = 10'd0;
        ifc.res_ready      = 1'b0;

        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // single image: launch timing, read latency, first result
        push_px(784, 0);
        chk("img1 bank_full", 32'(ifc.bank_full), 32'd1);
        chk("img1 start not yet", 32'(ifc.eng_start), 32'd0);
        chk("img1 other bank ready", 32'(ifc.pix_ready), 32'd1);
        step();
        chk("img1 start pulse", 32'(ifc.eng_start), 32'd1);
        step();
        chk("img1 start one wide", 32'(ifc.eng_start), 32'd0);
        run_table(tab1, "img1 read");
        engine_done(4'd7);
        chk("img1 res_valid", 32'(ifc.res_valid), 32'd1);
        chk("img1 res_digit", 32'(ifc.res_digit), 32'd7);
        chk("img1 bank retired", 32'(ifc.bank_full), 32'd0);
        ifc.res_ready = 1'b1;
        step();
        ifc.res_ready = 1'b0;
        chk("img1 fifo drained", 32'(ifc.res_valid), 32'd0);

        // back-to-back images with a stalled engine
        push_px(784, 0);
        push_px(784, 1);
        chk("b2b pix_ready low", 32'(ifc.pix_ready), 32'd0);
        chk("b2b both banks", 32'(ifc.bank_full), 32'd3);
        chk("b2b no drop yet", 32'(ifc.pix_drop), 32'd0);
        ifc.pix_valid = 1'b1;
        step();
        ifc.pix_valid = 1'b0;
        chk("b2b pix_drop", 32'(ifc.pix_drop), 32'd1);
        engine_done(4'd0);
        chk("b2b ready after done", 32'(ifc.pix_ready), 32'd1);
        chk("b2b bank0 left", 32'(ifc.bank_full), 32'd1);
        push_px(784, 2);
        engine_done(4'd1);
        engine_done(4'd2);
        pop_chk(4'd0);
        pop_chk(4'd1);
        pop_chk(4'd2);
        chk("b2b fifo empty", 32'(ifc.res_valid), 32'd0);

        // launch gated by weights_ready
        ifc.weights_ready = 1'b0;
        push_px(784, 0);
        step();
        step();
        step();
        chk("wr gate no start", 32'(ifc.eng_start), 32'd0);
        chk("wr gate bank full", 32'(ifc.bank_full), 32'd1);
        ifc.weights_ready = 1'b1;
        step();
        chk("wr gate start", 32'(ifc.eng_start), 32'd1);
        engine_done(4'd3);
        pop_chk(4'd3);

        // FIFO-full launch gating with no consumer
        l0 = launches;
        for (int i = 0; i < 4; i++) begin
            push_px(784, i);
            engine_done(4'(10 + i));
        end
        push_px(784, 0);
        step();
        step();
        step();
        chk("fifo full launches", 32'(launches - l0), 32'd4);
        chk("fifo full no start", 32'(ifc.eng_start), 32'd0);
        push_px(784, 0);
        chk("fifo full pix_ready", 32'(ifc.pix_ready), 32'd0);
        chk("fifo full banks", 32'(ifc.bank_full), 32'd3);
        pop_chk(4'd10);
        step();
        chk("fifo pop start", 32'(ifc.eng_start), 32'd1);
        step();
        chk("fifo fifth launch", 32'(launches - l0), 32'd5);
        engine_done(4'd14);
        step();
        chk("fifo refull no start", 32'(ifc.eng_start), 32'd0);
        pop_chk(4'd11);
        engine_done(4'd15);
        pop_chk(4'd12);
        pop_chk(4'd13);
        pop_chk(4'd14);
        pop_chk(4'd15);
        chk("fifo drained", 32'(ifc.res_valid), 32'd0);

        // abort mid-image, then abort coincident with a pixel
        ifc.weights_ready = 1'b0;
        push_px(300, 50);
        ifc.img_abort = 1'b1;
        step();
        ifc.img_abort = 1'b0;
        push_px(5, 50);
        ifc.pix_valid = 1'b1;
        ifc.pix_data  = 8'd99;
        ifc.img_abort = 1'b1;
        step();
        ifc.img_abort = 1'b0;
        ifc.pix_valid = 1'b0;
        push_px(784, 0);
        chk("abort one bank full", 32'(ifc.bank_full), 32'd2);
        chk("abort other ready", 32'(ifc.pix_ready), 32'd1);
        run_table(tab2, "abort read");
        ifc.weights_ready = 1'b1;
        engine_done(4'd4);
        pop_chk(4'd4);

        // reset in the middle of a run
        push_px(784, 0);
        engine_done(4'd9);
        push_px(784, 0);
        begin
            int t = 0;
            while (!ifc.eng_busy && t < 50) begin
                step();
                t++;
            end
        end
        chk("pre-rst busy", 32'(ifc.eng_busy), 32'd1);
        chk("pre-rst res_valid", 32'(ifc.res_valid), 32'd1);
        chk("pre-rst pix_drop", 32'(ifc.pix_drop), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("mid-run rst");
        step();
        rst = 1'b0;
        push_px(784, 0);
        engine_done(4'd6);
        chk("post-rst res_digit", 32'(ifc.res_digit), 32'd6);
`ifdef SCHED_SEQ_EN
        chk("post-rst res_seq", 32'(ifc.res_seq), 32'd0);
`endif
        pop_chk(4'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inference_scheduler.md
# inference_scheduler

Sequences MNIST images through the softmax inference engine. Incoming preprocessed pixels are captured into a two-bank (ping-pong) image buffer, so one image can be received while the other is being classified. The block launches the engine on each full bank in arrival order and serves the engine's pixel reads from the active bank. Predicted digits are queued in a small result FIFO for the UART/display side. It sits between the pixel receiver and the `inference` engine, alongside the weight loader.

## Interface
Parameters:
- `NUM_PIXELS`, 784, pixels per image
- `RESULT_DEPTH`, 4, result FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1, clock
- `rst` in 1, reset: synchronous, active-high; clock `clk`
- `pix_valid` in 1, pixel strobe
- `pix_data` in 8, signed preprocessed pixel
- `pix_ready` out 1, write bank can accept a pixel
- `img_abort` in 1, discard the partially received image
- `pix_drop` out 1, sticky: a pixel was offered while `pix_ready`=0
- `weights_ready` in 1, from the weight loader
- `eng_start` out 1, one-cycle start pulse to the engine
- `eng_busy` in 1, engine busy
- `eng_done` in 1, engine done pulse
- `eng_digit` in 4, engine `predicted_digit`
- `eng_input_addr` in 10, engine pixel address
- `eng_input_pixel` out 8, pixel read from the active bank
- `res_valid` out 1, result FIFO not empty
- `res_digit` out 4, head-of-FIFO digit
- `res_ready` in 1, consumer pops the FIFO head
- `bank_full` out 2, per-bank FULL/RUNNING status

## Operation
- Each bank has a state: EMPTY, FULL, or RUNNING.
- **Fill side.**
  - `wr_bank` starts at 0; `wr_cnt` counts 0..NUM_PIXELS-1.
  - `pix_ready` = (state[wr_bank]==EMPTY). This is combinational from registered state.
  - A pixel is accepted when `pix_valid && pix_ready`. The pixel is written at `wr_cnt`, then `wr_cnt` increments.
  - On the accept with `wr_cnt`==NUM_PIXELS-1: `wr_cnt`←0, the bank becomes FULL, and `wr_bank` toggles.
  - `img_abort` sets `wr_cnt`←0 and leaves bank state unchanged. If abort and a pixel accept occur in the same cycle, abort wins and the pixel is discarded.
  - `pix_valid && !pix_ready` sets `pix_drop`. Only `rst` clears it.
- **Launch FSM**, states S_IDLE, S_START, S_RUN:
  - S_IDLE → S_START when state[rd_bank]==FULL && `weights_ready` && !`eng_busy` && (fifo_count + 0) < RESULT_DEPTH. `eng_start`=1 is registered for the S_START cycle only. rd_bank becomes RUNNING.
  - S_START → S_RUN when `eng_busy`=1.
  - S_RUN → S_IDLE on `eng_done`: push `eng_digit`, set rd_bank to EMPTY, toggle `rd_bank`.
  - `weights_ready` falling mid-run has no effect on the run in progress. Launch is only gated in S_IDLE.
- Banks are processed strictly in fill order, because both `wr_bank` and `rd_bank` alternate.
- **Read mux.** `eng_input_pixel` is a synchronous read of bank[rd_bank] at `eng_input_addr`, with 1-cycle latency. This matches the weight RAM latency.
- **Result FIFO.**
  - Push on `eng_done`; pop on `res_valid && res_ready`.
  - Simultaneous push and pop is legal; the count stays the same.
  - Launch gating guarantees the FIFO never overflows.
- **Reset.** All banks EMPTY, `wr_cnt`=0, `wr_bank`=`rd_bank`=0, FSM in S_IDLE, FIFO empty. Output values after reset:
  - `pix_ready`=1
  - `pix_drop`=0, `eng_start`=0
  - `res_valid`=0, `res_digit`=0
  - `bank_full`=0
  - `eng_input_pixel`=0

  Reset during a run abandons it. The engine must be reset by the same `rst`.

## Timing
- Last pixel accepted at edge N:
  - `bank_full` bit set after edge N.
  - Earliest `eng_start` high in cycle N+1, one cycle wide.
- `eng_done` at edge M: `res_valid` high after M if the FIFO was empty; the bank is EMPTY and `pix_ready` reasserts after M.
- Full-rate input: when both banks are FULL or RUNNING, `pix_ready`=0 until the running bank retires.
- The pixel RAM read address is used unregistered from `eng_input_addr`. Read data is registered.

## Configuration
- `SCHED_SEQ_EN` defined:
  - Adds output `res_seq[7:0]`, an image sequence number. It is stored with each result and wraps 255→0.
  - Sequence numbers are assigned at bank FULL and reset to 0.
  - Aborted images do not consume a number.
- Undefined: no `res_seq` port and no sequence storage.

## Structure
- Shared package `inference_pkg`:
  - `NUM_PIXELS`, `NUM_CLASSES`
  - bank state enum (EMPTY/FULL/RUNNING)
  - FSM state localparams
- Sub-module `image_bank_ram`: 2×NUM_PIXELS×8 with one write port and one synchronous read port. Bank select is the address MSB.
- The result FIFO is inline; a generic FIFO is not needed.

## Test plan
- Stream 784 pixels (value k mod 128) with `weights_ready`=1 → `eng_start` pulses once on the cycle after the last accept; engine addr 5 returns 5 one cycle later; `eng_done` with digit 7 gives `res_valid`=1, `res_digit`=7.
- Stream 3 images back-to-back with a stalled engine → `pix_ready` drops after image 2 and an extra `pix_valid` sets `pix_drop`; after the first done, `pix_ready` rises; results come out in order 0,1,2.
- `weights_ready`=0 with a full bank → no `eng_start`; raising it → `eng_start` on the next cycle.
- `res_ready`=0, RESULT_DEPTH=4, 6 images → exactly 4 launches; popping one allows the 5th launch.
- `img_abort` after 300 pixels, then 784 fresh pixels → bank holds only the fresh pixels; `img_abort` coincident with a pixel → that pixel is discarded.
- `rst` mid-run → all outputs at reset values on the next cycle; `SCHED_SEQ_EN` build: after a reset the first result has `res_seq`=0.
